// File: rtl/cache_fill_arbiter.sv
// Shares one main-memory read port between the I-cache and D-cache miss paths.
// Grants a missing cache, streams its block reads and drives that cache's fill writes.
module cache_fill_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss,
    input  logic [ADDR_WIDTH-1:0] i_miss_addr,
    input  logic                  d_miss,
    input  logic [ADDR_WIDTH-1:0] d_miss_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  i_fill_wr,
    output logic                  d_fill_wr,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  arbiter_select,
    output logic                  busy,
    output logic                  fill_done
);

    // Counter width holds 0..WORDS_PER_BLOCK; a block spans 2*WORDS bytes.
    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [CW-1:0] LAST  = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0] WORDS = CW'(WORDS_PER_BLOCK);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
        ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nx;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         iss_cnt;
    logic [CW-1:0]         rx_cnt;
    logic                  grant;
    logic                  fill_wr;

    // State, owner, block base and issue/return counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sel     <= 1'b0;
            base    <= '0;
            iss_cnt <= '0;
            rx_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                sel     <= d_miss;
                base    <= (d_miss ? d_miss_addr : i_miss_addr) & BLK_MASK;
                iss_cnt <= '0;
                rx_cnt  <= '0;
            end else begin
                if (mem_en)
                    iss_cnt <= iss_cnt + 1'b1;
                if (fill_wr)
                    rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Next state, read issue and fill write; returns are accepted in REQ too.
    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_wr   = 1'b0;
        fill_addr = '0;
        fill_data = '0;
        busy      = 1'b0;
        fill_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_miss || d_miss) begin
                    grant    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = base | ADDR_WIDTH'({iss_cnt, 1'b0});
                if (iss_cnt == LAST)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                state_nx  = IDLE;
            end
        endcase
        if ((state == REQ || state == DRAIN) && mem_data_valid
            && rx_cnt < WORDS) begin
            fill_wr   = 1'b1;
            fill_addr = base | ADDR_WIDTH'({rx_cnt, 1'b0});
            fill_data = mem_data_in;
            if (rx_cnt == LAST)
                state_nx = DONE;
        end
    end

    assign i_fill_wr      = fill_wr & ~sel;
    assign d_fill_wr      = fill_wr & sel;
    assign arbiter_select = sel;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: table of single fills plus multi-cycle sequences.
// Fixed-latency memory model feeds a write scoreboard and an issue scoreboard.
module tb_cache_fill_arbiter;

    localparam int L = 4;

    typedef struct {
        logic        sel;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    typedef struct {
        int   cyc;
        logic sel;
    } done_t;

    typedef struct {
        logic        i_miss;
        logic [15:0] i_addr;
        logic        d_miss;
        logic [15:0] d_addr;
        logic        exp_sel;
        logic [15:0] exp_base;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        i_fill_wr;
    logic        d_fill_wr;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        arbiter_select;
    logic        busy;
    logic        fill_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t         exp_q[$];
    logic [15:0] iss_q[$];
    rd_t         mq[$];
    done_t       done_q[$];

    logic        inj_valid = 1'b0;
    logic [15:0] inj_data  = '0;
    logic        hold_en   = 1'b0;

    vec_t vecs[6];

    cache_fill_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .i_fill_wr      (i_fill_wr),
        .d_fill_wr      (d_fill_wr),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .arbiter_select (arbiter_select),
        .busy           (busy),
        .fill_done      (fill_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5AC3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_fill(input logic sel, input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] a;
            a = base | 16'(k * 2);
            iss_q.push_back(a);
            exp_q.push_back('{sel, a, mdata(a)});
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dones(input int cnt, input int limit);
        int n;
        n = 0;
        while (done_q.size() < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_q.size(), cnt);
    endtask

    // Memory request capture: returns due L cycles after issue, in order.
    initial forever begin
        @(negedge clk);
        if (mem_en)
            mq.push_back('{mem_addr, cyc + L +
                ((hold_en && mem_addr[3:0] == 4'h4) ? 6 : 0)});
    end

    // Memory return driver, with optional injected stray returns.
    initial begin
        mem_data_valid = 1'b0;
        mem_data_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_data_valid = 1'b0;
            mem_data_in    = '0;
            if (inj_valid) begin
                mem_data_valid = 1'b1;
                mem_data_in    = inj_data;
                inj_valid      = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                rd_t r;
                r = mq.pop_front();
                mem_data_valid = 1'b1;
                mem_data_in    = mdata(r.addr);
            end
        end
    end

    // Output monitor: issue order, fill writes, idle fill bus, done pulses.
    initial forever begin
        @(negedge clk);
        if (mem_en) begin
            if (iss_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_issue: got mem_addr 0x%0h, expected none (cycle %0d)",
                         mem_addr, cyc);
            end else begin
                logic [15:0] ea;
                ea = iss_q.pop_front();
                chk("mem_addr", mem_addr, ea);
            end
        end
        if (i_fill_wr || d_fill_wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_wr: got wr i=%0b d=%0b addr 0x%0h, expected none (cycle %0d)",
                         i_fill_wr, d_fill_wr, fill_addr, cyc);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_sel", {d_fill_wr, i_fill_wr}, w.sel ? 2'b10 : 2'b01);
                chk("fill_addr", fill_addr, w.addr);
                chk("fill_data", fill_data, w.data);
            end
        end else begin
            chk("idle_fill_bus", {fill_addr, fill_data}, 0);
        end
        if (fill_done)
            done_q.push_back('{cyc, arbiter_select});
    end

    task automatic run_row(input vec_t v, input int idx);
        int t0;
        @(posedge clk);
        #1;
        done_q.delete();
        push_fill(v.exp_sel, v.exp_base);
        i_miss      = v.i_miss;
        i_miss_addr = v.i_addr;
        d_miss      = v.d_miss;
        d_miss_addr = v.d_addr;
        t0          = cyc;
        @(negedge clk);
        chk($sformatf("row%0d_c0_busy", idx), busy, 0);
        @(posedge clk);
        #1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        @(negedge clk);
        chk($sformatf("row%0d_c1_en", idx), mem_en, 1);
        chk($sformatf("row%0d_sel", idx), arbiter_select, v.exp_sel);
        wait_dones(1, 60);
        if (done_q.size() > 0)
            chk($sformatf("row%0d_done_cyc", idx), done_q[0].cyc - t0,
                v.exp_done);
        @(negedge clk);
        chk($sformatf("row%0d_idle", idx), busy, 0);
        chk($sformatf("row%0d_sb_empty", idx), exp_q.size() + iss_q.size(), 0);
    endtask

    initial begin
        int t0;
        vecs[0] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 16'h1230, 13};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'hA0F2, 1'b1, 16'hA0F0, 13};
        vecs[2] = '{1'b1, 16'h0040, 1'b1, 16'h3C2E, 1'b1, 16'h3C20, 13};
        vecs[3] = '{1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'hFFF0, 13};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h000F, 1'b1, 16'h0000, 13};
        vecs[5] = '{1'b1, 16'h8009, 1'b0, 16'h7777, 1'b0, 16'h8000, 13};

        rst         = 1'b0;
        i_miss      = 1'b0;
        i_miss_addr = '0;
        d_miss      = 1'b0;
        d_miss_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", {mem_en, mem_addr, i_fill_wr, d_fill_wr,
            fill_addr, fill_data, arbiter_select, busy, fill_done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            run_row(vecs[i], i);

        // Both miss: D first, I granted in first IDLE cycle after DONE.
        @(posedge clk);
        #1;
        done_q.delete();
        push_fill(1'b1, 16'hA0F0);
        push_fill(1'b0, 16'h0040);
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'hA0F2;
        t0 = cyc;
        wait_cyc(t0 + 1);
        d_miss = 1'b0;
        wait_cyc(t0 + 14);
        @(negedge clk);
        chk("t2_gap_idle", busy, 0);
        wait_cyc(t0 + 15);
        @(negedge clk);
        chk("t2_i_en", mem_en, 1);
        chk("t2_i_sel", arbiter_select, 0);
        @(posedge clk);
        #1;
        i_miss = 1'b0;
        wait_dones(2, 80);
        if (done_q.size() == 2) begin
            chk("t2_d_done", done_q[0].cyc - t0, 13);
            chk("t2_d_sel", done_q[0].sel, 1);
            chk("t2_i_done", done_q[1].cyc - t0, 27);
            chk("t2_i_sel_done", done_q[1].sel, 0);
        end
        @(negedge clk);
        chk("t2_sb_empty", exp_q.size() + iss_q.size(), 0);

        // I miss pulses mid-fill and drops; stray return during DONE.
        @(posedge clk);
        #1;
        done_q.delete();
        push_fill(1'b1, 16'h2460);
        d_miss = 1'b1; d_miss_addr = 16'h246A;
        t0 = cyc;
        wait_cyc(t0 + 1);
        d_miss = 1'b0;
        wait_cyc(t0 + 3);
        i_miss = 1'b1; i_miss_addr = 16'h9990;
        wait_cyc(t0 + 6);
        i_miss = 1'b0;
        wait_cyc(t0 + 12);
        inj_data  = 16'h1357;
        inj_valid = 1'b1;
        wait_cyc(t0 + 13);
        @(negedge clk);
        chk("t3_done", fill_done, 1);
        chk("t3_done_no_wr", {i_fill_wr, d_fill_wr}, 0);
        repeat (6) @(negedge clk);
        chk("t3_idle", busy, 0);
        chk("t3_one_done", done_q.size(), 1);
        chk("t3_sb_empty", exp_q.size() + iss_q.size(), 0);

        // Third word withheld six extra cycles.
        @(posedge clk);
        #1;
        done_q.delete();
        hold_en = 1'b1;
        push_fill(1'b0, 16'h5550);
        i_miss = 1'b1; i_miss_addr = 16'h555C;
        t0 = cyc;
        wait_cyc(t0 + 1);
        i_miss = 1'b0;
        wait_cyc(t0 + 10);
        @(negedge clk);
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_quiet", {mem_en, i_fill_wr, d_fill_wr, fill_done}, 0);
        wait_dones(1, 80);
        if (done_q.size() > 0)
            chk("t4_done_cyc", done_q[0].cyc - t0, 19);
        hold_en = 1'b0;
        @(negedge clk);
        chk("t4_idle", busy, 0);
        chk("t4_sb_empty", exp_q.size() + iss_q.size(), 0);

        // Reset mid D fill; in-flight returns must not write.
        @(posedge clk);
        #1;
        done_q.delete();
        push_fill(1'b1, 16'h3C20);
        d_miss = 1'b1; d_miss_addr = 16'h3C28;
        t0 = cyc;
        wait_cyc(t0 + 1);
        d_miss = 1'b0;
        wait_cyc(t0 + 7);
        rst = 1'b0;
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        chk("t5_rst_outputs", {mem_en, mem_addr, i_fill_wr, d_fill_wr,
            fill_addr, fill_data, arbiter_select, busy, fill_done}, 0);
        wait_cyc(t0 + 9);
        rst = 1'b1;
        wait_cyc(t0 + 10);
        @(negedge clk);
        chk("t5_late_ret_no_wr", {i_fill_wr, d_fill_wr, busy}, 0);
        chk("t5_no_done", done_q.size(), 0);
        run_row('{1'b1, 16'h7E5A, 1'b0, 16'h0000, 1'b0, 16'h7E50, 13}, 6);

        // Stray return while idle.
        @(posedge clk);
        #1;
        inj_data  = 16'hBEEF;
        inj_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_stray_no_wr", {i_fill_wr, d_fill_wr}, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fill_data", fill_data, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
